otter_fetch_stage: RTL and testbench
====================================

# otter_fetch_stage

Instruction-fetch control and IF/ID pipeline register for the pipelined OTTER RV32I core. The block sits directly downstream of the PC stage. It takes the current PC and PC+4 from that stage and issues one request at a time to instruction memory over a ready/valid handshake. It latches the returned word into the IF/ID register, and drives `PC_WRITE` back to the PC stage so the PC advances only when an instruction is actually handed to decode. It also handles decode stalls and control-flow flushes, including discarding an in-flight response.

## Interface
- No parameters; XLEN fixed at 32.
- `CLK` in 1: clock; all state updates on rising edge.
- `RST` in 1: reset, synchronous, active-high.
- `PC_IN` in 32: current PC from the PC stage.
- `PC_INC_IN` in 32: PC+4 from the PC stage.
- `PC_WRITE` out 1: enables the PC register load this cycle.
- `IMEM_REQ` out 1: fetch request valid.
- `IMEM_ADDR` out 32: fetch address; equals `PC_IN` whenever `IMEM_REQ`=1.
- `IMEM_READY` in 1: memory accepts the request this cycle.
- `IMEM_RVALID` in 1: response valid, at least 1 cycle after acceptance.
- `IMEM_RDATA` in 32: instruction word, valid with `IMEM_RVALID`.
- `STALL` in 1: decode cannot accept; hold the IF/ID register.
- `FLUSH` in 1: redirect (branch taken, jump, trap, mret). The hazard unit sets `PC_SOURCE` for the target in the same cycle.
- `ID_VALID` out 1: IF/ID holds a real instruction.
- `ID_INSTR` out 32: instruction to decode; NOP (32'h00000013) when not valid.
- `ID_PC` out 32: PC of `ID_INSTR`.
- `ID_PC_INC` out 32: PC+4 of `ID_INSTR`.

## Operation
The block has four states: FETCH, WAIT, HOLD, DRAIN.

- **FETCH**
  - `IMEM_REQ` = !FLUSH; `IMEM_ADDR` = `PC_IN`.
  - When `IMEM_REQ`&`IMEM_READY`: latch `PC_IN`/`PC_INC_IN` into fetch_pc/fetch_pc_inc and go to WAIT.
  - `IMEM_RVALID` is ignored in FETCH.
- **WAIT**
  - `IMEM_REQ`=0.
  - On `IMEM_RVALID` with !STALL: load IF/ID with {1, RDATA, fetch_pc, fetch_pc_inc}, assert `PC_WRITE`, go to FETCH.
  - On `IMEM_RVALID` with STALL: capture RDATA into the hold buffer and go to HOLD.
- **HOLD**
  - When !STALL: load IF/ID from the hold buffer, assert `PC_WRITE`, go to FETCH.
- **DRAIN**
  - `IMEM_REQ`=0.
  - On `IMEM_RVALID`: drop the data and go to FETCH.
- **IF/ID register when not loaded:**
  - With STALL=1, it holds its value.
  - With STALL=0, it becomes a bubble (`ID_VALID`=0, `ID_INSTR`=NOP, `ID_PC`/`ID_PC_INC` unchanged).
- **FLUSH** has highest priority and overrides STALL.
  - `PC_WRITE`=1 that cycle, so the PC loads the redirect target.
  - The IF/ID register becomes a bubble next cycle.
  - FETCH → FETCH, with the request suppressed.
  - WAIT without RVALID → DRAIN.
  - WAIT with RVALID → FETCH, and the response is dropped.
  - HOLD → FETCH, and the buffer is dropped.
  - DRAIN → DRAIN.
- `PC_WRITE` is 0 in every case not listed above. The PC therefore never advances while an instruction is outstanding or held.
- Only one request is ever outstanding.

## Timing
- **Reset** (next edge): state=FETCH; `ID_VALID`=0, `ID_INSTR`=NOP, `ID_PC`=0, `ID_PC_INC`=0; hold buffer and fetch_pc=0.
  - `PC_WRITE`=0 and `IMEM_REQ`=0 while RST=1.
  - Reset mid-WAIT or mid-DRAIN abandons the request. A stray RVALID afterwards lands in FETCH and is ignored.
- **Combinational outputs:** `IMEM_REQ`, `IMEM_ADDR`, `PC_WRITE`. The `ID_*` outputs are registered.
- **Latency:** request accepted at edge N, RVALID in cycle N+k (k≥1), `ID_*` valid after edge N+k.
- **Throughput:** with k=1 and no stalls, one instruction every 2 cycles.
- **Stall cost:** HOLD adds exactly the number of stalled cycles; the instruction is neither lost nor duplicated.

## Structure
- `otter_fetch_pkg`: fetch-state enum typedef; `NOP_INSTR` = 32'h00000013 constant.
- Sub-module `otter_if_id_reg`: IF/ID register with load, bubble and hold controls. The FSM and hold buffer stay in the top module.

## Test plan
- **Reset then streaming:** PC_IN=0x0, then 0x4 after `PC_WRITE`; READY=1, RVALID 1 cycle after acceptance, RDATA=0x00500093/0x00A00113 → ID shows (0x0, 0x00500093) then (0x4, 0x00A00113), 2 cycles apart; `PC_WRITE` is a single-cycle pulse each time.
- **Slow memory:** READY low 3 cycles, then RVALID 4 cycles after acceptance → `IMEM_ADDR` stable throughout, `ID_VALID`=0 bubbles, exactly one `PC_WRITE`.
- **Stall on return:** STALL=1 for 3 cycles spanning RVALID → HOLD entered, ID unchanged for 3 cycles; then the held word appears with `PC_WRITE` on the cycle STALL drops.
- **Flush in WAIT:** FLUSH one cycle before RVALID for an instruction at 0x8, redirect target 0x40 → response at 0x8 discarded (never `ID_VALID`), next request `IMEM_ADDR`=0x40.
- **Flush+STALL and flush in HOLD:** both asserted in HOLD → buffer dropped, `PC_WRITE`=1, `ID_VALID`=0 next cycle.
- **RST mid-WAIT:** RST pulse while a request is outstanding, then a stray RVALID → all outputs at reset values, stray word ignored, fetch restarts from `PC_IN`.

Source files
------------

// File: rtl/otter_fetch_pkg.sv
// Shared types and constants for the OTTER instruction-fetch stage.
package otter_fetch_pkg;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DRAIN = 2'd3
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;

endpackage

// File: rtl/otter_if_id_reg.sv
// IF/ID pipeline register: load has priority, then bubble, otherwise hold.
module otter_if_id_reg
  import otter_fetch_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_load,
  input  logic        i_bubble,
  input  logic [31:0] i_instr,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_pc_inc,
  output logic        o_valid,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc,
  output logic [31:0] o_pc_inc
);

  logic        r_valid;
  logic [31:0] r_instr;
  logic [31:0] r_pc;
  logic [31:0] r_pc_inc;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid  <= 1'b0;
      r_instr  <= NOP_INSTR;
      r_pc     <= 32'd0;
      r_pc_inc <= 32'd0;
    end else if (i_load) begin
      r_valid  <= 1'b1;
      r_instr  <= i_instr;
      r_pc     <= i_pc;
      r_pc_inc <= i_pc_inc;
    end else if (i_bubble) begin
      // A bubble keeps the PCs so decode still sees a coherent address.
      r_valid  <= 1'b0;
      r_instr  <= NOP_INSTR;
    end
  end

  assign o_valid  = r_valid;
  assign o_instr  = r_instr;
  assign o_pc     = r_pc;
  assign o_pc_inc = r_pc_inc;

endmodule

// File: rtl/otter_fetch_stage.sv
// Fetch control FSM with one outstanding imem request, hold buffer and IF/ID register.
// Handshake: a request transfers when IMEM_REQ & IMEM_READY; IMEM_RDATA is consumed only when IMEM_RVALID.
module otter_fetch_stage
  import otter_fetch_pkg::*;
(
  input  logic         CLK,
  input  logic         RST,
  input  logic [31:0]  PC_IN,
  input  logic [31:0]  PC_INC_IN,
  output logic         PC_WRITE,
  output logic         IMEM_REQ,
  output logic [31:0]  IMEM_ADDR,
  input  logic         IMEM_READY,
  input  logic         IMEM_RVALID,
  input  logic [31:0]  IMEM_RDATA,
  input  logic         STALL,
  input  logic         FLUSH,
  output logic         ID_VALID,
  output logic [31:0]  ID_INSTR,
  output logic [31:0]  ID_PC,
  output logic [31:0]  ID_PC_INC,
  output fetch_state_t DBG_STATE
);

  fetch_state_t r_state;
  logic [31:0]  r_fetch_pc;
  logic [31:0]  r_fetch_pc_inc;
  logic [31:0]  r_hold_instr;

  fetch_state_t w_next;
  logic         w_load;
  logic         w_bubble;
  logic [31:0]  w_load_instr;
  logic         w_cap_fetch;
  logic         w_cap_hold;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state        <= ST_FETCH;
      r_fetch_pc     <= 32'd0;
      r_fetch_pc_inc <= 32'd0;
      r_hold_instr   <= 32'd0;
    end else begin
      r_state <= w_next;
      if (w_cap_fetch) begin
        r_fetch_pc     <= PC_IN;
        r_fetch_pc_inc <= PC_INC_IN;
      end
      if (w_cap_hold) r_hold_instr <= IMEM_RDATA;
    end
  end

  always_comb begin
    w_next       = r_state;
    IMEM_REQ     = 1'b0;
    PC_WRITE     = 1'b0;
    w_load       = 1'b0;
    w_bubble     = 1'b0;
    w_load_instr = IMEM_RDATA;
    w_cap_fetch  = 1'b0;
    w_cap_hold   = 1'b0;
    if (RST) begin
      w_next = ST_FETCH;
    end else if (FLUSH) begin
      // Redirect: the PC loads the target, anything in flight is abandoned.
      PC_WRITE = 1'b1;
      w_bubble = 1'b1;
      case (r_state)
        ST_WAIT:  w_next = IMEM_RVALID ? ST_FETCH : ST_DRAIN;
        ST_DRAIN: w_next = ST_DRAIN;
        default:  w_next = ST_FETCH;
      endcase
    end else begin
      case (r_state)
        ST_FETCH: begin
          IMEM_REQ = 1'b1;
          w_bubble = !STALL;
          if (IMEM_READY) begin
            w_cap_fetch = 1'b1;
            w_next      = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (IMEM_RVALID && !STALL) begin
            w_load   = 1'b1;
            PC_WRITE = 1'b1;
            w_next   = ST_FETCH;
          end else if (IMEM_RVALID) begin
            w_cap_hold = 1'b1;
            w_next     = ST_HOLD;
          end else begin
            w_bubble = !STALL;
          end
        end
        ST_HOLD: begin
          w_load_instr = r_hold_instr;
          if (!STALL) begin
            w_load   = 1'b1;
            PC_WRITE = 1'b1;
            w_next   = ST_FETCH;
          end
        end
        default: begin
          w_bubble = !STALL;
          if (IMEM_RVALID) w_next = ST_FETCH;
        end
      endcase
    end
  end

  assign IMEM_ADDR = PC_IN;
  assign DBG_STATE = r_state;

  otter_if_id_reg u_if_id (
    .i_clk    (CLK),
    .i_rst    (RST),
    .i_load   (w_load),
    .i_bubble (w_bubble),
    .i_instr  (w_load_instr),
    .i_pc     (r_fetch_pc),
    .i_pc_inc (r_fetch_pc_inc),
    .o_valid  (ID_VALID),
    .o_instr  (ID_INSTR),
    .o_pc     (ID_PC),
    .o_pc_inc (ID_PC_INC)
  );

endmodule

// File: tb/tb_otter_fetch_stage.sv
// Bench for otter_fetch_stage: PC-stage and memory models around the DUT, transaction-level expectations.
module tb_otter_fetch_stage;
  import otter_fetch_pkg::*;

  // clock / reset
  logic         CLK = 1'b0;
  logic         RST = 1'b0;
  logic [31:0]  PC_IN = '0;
  logic [31:0]  PC_INC_IN = '0;
  logic         PC_WRITE;
  logic         IMEM_REQ;
  logic [31:0]  IMEM_ADDR;
  logic         IMEM_READY = 1'b0;
  logic         IMEM_RVALID = 1'b0;
  logic [31:0]  IMEM_RDATA = '0;
  logic         STALL = 1'b0;
  logic         FLUSH = 1'b0;
  logic         ID_VALID;
  logic [31:0]  ID_INSTR;
  logic [31:0]  ID_PC;
  logic [31:0]  ID_PC_INC;
  fetch_state_t dbg_state;

  always #5 CLK = ~CLK;

  otter_fetch_stage dut (
    .CLK(CLK), .RST(RST), .PC_IN(PC_IN), .PC_INC_IN(PC_INC_IN), .PC_WRITE(PC_WRITE),
    .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR), .IMEM_READY(IMEM_READY),
    .IMEM_RVALID(IMEM_RVALID), .IMEM_RDATA(IMEM_RDATA), .STALL(STALL), .FLUSH(FLUSH),
    .ID_VALID(ID_VALID), .ID_INSTR(ID_INSTR), .ID_PC(ID_PC), .ID_PC_INC(ID_PC_INC),
    .DBG_STATE(dbg_state)
  );

  // scoreboard state
  int          total = 0;
  int          bad = 0;
  logic [63:0] exp_q[$];     // accepted request {pc, pc+4} not yet delivered or killed
  bit          has_data;     // its word has come back
  logic [31:0] it_data;
  bit          drain;        // a killed request whose response is still due
  int          mem_cnt;      // cycles until the memory answers, -1 if nothing pending
  int          lat_lo, lat_hi;
  bit          noise_en;
  logic [31:0] pc;           // PC-stage register
  logic [31:0] salt;
  logic        ev;
  logic [31:0] ei, epc, einc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h00500093;
    if (a == 32'h4) return 32'h00A00113;
    return (a * 32'h9E3779B1) ^ salt;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // driver: one clock cycle of PC stage + memory + hazard inputs
  task automatic step(input bit rst, input bit ready, input bit stall, input bit flush,
                      input logic [31:0] tgt);
    bit          rv, exp_req, exp_pcw, deliver, accepted;
    logic [31:0] rdata;
    logic [63:0] it;
    rv = (mem_cnt == 0);
    if (!rv && mem_cnt < 0 && exp_q.size() == 0 && !drain && noise_en)
      rv = ($urandom_range(0, 3) == 0);
    if (rv && drain) flush = 1'b0;
    rdata = $urandom;
    if (rv && mem_cnt == 0 && exp_q.size() != 0 && !has_data) rdata = mem_word(exp_q[0][63:32]);
    RST = rst; IMEM_READY = ready; STALL = stall; FLUSH = flush;
    PC_IN = pc; PC_INC_IN = pc + 32'd4;
    IMEM_RVALID = rv; IMEM_RDATA = rdata;
    #1;
    exp_req = !rst && !flush && exp_q.size() == 0 && !drain;
    chk("imem_req", IMEM_REQ, exp_req);
    if (exp_req) chk("imem_addr", IMEM_ADDR, pc);
    exp_pcw = 0; deliver = 0; accepted = 0; it = '0;
    if (rst) begin
      exp_q.delete(); has_data = 0; drain = 0;
    end else if (flush) begin
      exp_pcw = 1;
      if (exp_q.size() != 0 && !has_data && !rv) drain = 1;
      exp_q.delete(); has_data = 0;
    end else begin
      if (exp_q.size() != 0 && rv && !has_data) begin
        has_data = 1; it_data = rdata;
      end else if (drain && rv) begin
        drain = 0;
      end
      if (exp_q.size() != 0 && has_data && !stall) begin
        deliver = 1; exp_pcw = 1; it = exp_q.pop_front(); has_data = 0;
      end
      if (exp_req && ready) begin
        exp_q.push_back({pc, pc + 32'd4}); accepted = 1;
      end
    end
    chk("pc_write", PC_WRITE, exp_pcw);
    if (mem_cnt >= 0) mem_cnt--;
    if (accepted) mem_cnt = $urandom_range(lat_lo, lat_hi) - 1;
    if (rst) begin
      ev = 0; ei = NOP_INSTR; epc = 0; einc = 0;
    end else if (deliver) begin
      ev = 1; ei = it_data; epc = it[63:32]; einc = it[31:0];
    end else if (flush || !stall) begin
      ev = 0; ei = NOP_INSTR;
    end
    if (PC_WRITE === 1'b1) pc = flush ? tgt : pc + 32'd4;
    @(posedge CLK); #1;
    chk("id_valid", ID_VALID, ev);
    chk("id_instr", ID_INSTR, ei);
    chk("id_pc", ID_PC, epc);
    chk("id_pc_inc", ID_PC_INC, einc);
  endtask

  initial begin
    pc = 0; mem_cnt = -1; has_data = 0; drain = 0; noise_en = 0;
    lat_lo = 1; lat_hi = 1; salt = $urandom;
    ev = 0; ei = NOP_INSTR; epc = 0; einc = 0;
    @(posedge CLK); #1;

    // reset
    step(1, 0, 0, 0, 0);
    chk("rst_valid", ID_VALID, 1'b0);
    chk("rst_instr", ID_INSTR, 32'h00000013);
    chk("rst_pc", ID_PC, 32'h0);

    // streaming, one-cycle memory
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    chk("stream0_pc", ID_PC, 32'h0);
    chk("stream0_instr", ID_INSTR, 32'h00500093);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    chk("stream1_pc", ID_PC, 32'h4);
    chk("stream1_instr", ID_INSTR, 32'h00A00113);

    // slow memory: READY low 3 cycles, response 4 cycles after acceptance
    lat_lo = 4; lat_hi = 4;
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0);

    // stall spanning the response
    lat_lo = 2; lat_hi = 2;
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0);

    // flush in FETCH to 0x8, then flush in WAIT redirecting to 0x40
    step(0, 0, 0, 1, 32'h8);
    lat_lo = 3; lat_hi = 3;
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 32'h40);
    chk("flush_wait_bubble", ID_VALID, 1'b0);
    step(0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);

    // flush together with stall while holding a word
    lat_lo = 1; lat_hi = 1;
    step(0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 1, 32'h80);
    chk("flush_hold_bubble", ID_VALID, 1'b0);
    step(0, 0, 0, 0, 0);

    // reset while a request is outstanding, then a stray response
    lat_lo = 3; lat_hi = 3;
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    chk("rst_mid_pc", ID_PC, 32'h0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    lat_lo = 1; lat_hi = 1;
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0);

    // randomized traffic
    noise_en = 1; lat_lo = 1; lat_hi = 4;
    for (int i = 0; i < 600; i++)
      step(0, $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 9) == 0, 32'($urandom_range(0, 1023)) << 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
